vx_commit_packetizer: RTL and testbench

VX_COMMIT_PACKETIZER -- requirements
Module: VX_commit_packetizer

---
 rtl/vx_commit_packetizer_if.sv | 55 +++++
 rtl/vx_commit_packetizer.sv | 123 ++++++++++++
 tb/tb_vx_commit_packetizer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_commit_packetizer_if.sv
// Commit packetizer port bundle: one full-width result in, one beat-wide commit out.
// The master side feeds results and consumes beats; the slave side is the packetizer.
interface vx_commit_packetizer_if #(
  parameter int NUM_LANES  = 8,
  parameter int BEAT_LANES = 4,
  parameter int XLEN       = 32,
  parameter int NW_WIDTH   = 2,
  parameter int NR_BITS    = 5,
  parameter int UUID_WIDTH = 44,
  parameter int PC_BITS    = 30
);
  localparam int NUM_BEATS = NUM_LANES / BEAT_LANES;
  localparam int PID_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  logic                       valid_in;
  logic                       ready_in;
  logic [UUID_WIDTH-1:0]      in_uuid;
  logic [NW_WIDTH-1:0]        in_wid;
  logic [PC_BITS-1:0]         in_PC;
  logic                       in_wb;
  logic [NR_BITS-1:0]         in_rd;
  logic [NUM_LANES-1:0]       in_tmask;
  logic [NUM_LANES*XLEN-1:0]  in_data;
  logic                       in_sop;
  logic                       in_eop;

  logic                       valid_out;
  logic                       ready_out;
  logic [UUID_WIDTH-1:0]      out_uuid;
  logic [NW_WIDTH-1:0]        out_wid;
  logic [PC_BITS-1:0]         out_PC;
  logic                       out_wb;
  logic [NR_BITS-1:0]         out_rd;
  logic [BEAT_LANES-1:0]      out_tmask;
  logic [BEAT_LANES*XLEN-1:0] out_data;
  logic                       out_sop;
  logic                       out_eop;
  logic [PID_W-1:0]           out_pid;

  modport master (
    output valid_in, in_uuid, in_wid, in_PC, in_wb, in_rd, in_tmask, in_data, in_sop, in_eop,
    output ready_out,
    input  ready_in,
    input  valid_out, out_uuid, out_wid, out_PC, out_wb, out_rd, out_tmask, out_data,
    input  out_sop, out_eop, out_pid
  );

  modport slave (
    input  valid_in, in_uuid, in_wid, in_PC, in_wb, in_rd, in_tmask, in_data, in_sop, in_eop,
    input  ready_out,
    output ready_in,
    output valid_out, out_uuid, out_wid, out_PC, out_wb, out_rd, out_tmask, out_data,
    output out_sop, out_eop, out_pid
  );
endinterface

// File: rtl/vx_commit_packetizer.sv
// Splits one captured multi-lane commit result into beat-wide slices, sending only
// slices with active lanes, back-to-back with the next result when possible.
module vx_commit_packetizer #(
  parameter int NUM_LANES  = 8,
  parameter int BEAT_LANES = 4,
  parameter int XLEN       = 32,
  parameter int NW_WIDTH   = 2,
  parameter int NR_BITS    = 5,
  parameter int UUID_WIDTH = 44,
  parameter int PC_BITS    = 30
) (
  input logic                    clk,
  input logic                    reset,
  vx_commit_packetizer_if.slave  i_if
);
  localparam int NUM_BEATS = NUM_LANES / BEAT_LANES;
  localparam int PID_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    r_state;
  logic [PID_W-1:0]          r_pid;
  logic [PID_W-1:0]          r_last_pid;
  logic                      r_first;
  logic [UUID_WIDTH-1:0]     r_uuid;
  logic [NW_WIDTH-1:0]       r_wid;
  logic [PC_BITS-1:0]        r_PC;
  logic                      r_wb;
  logic [NR_BITS-1:0]        r_rd;
  logic [NUM_LANES-1:0]      r_tmask;
  logic [NUM_LANES*XLEN-1:0] r_data;
  logic                      r_sop;
  logic                      r_eop;

  logic [NUM_BEATS-1:0]       w_in_active;
  logic [NUM_BEATS-1:0]       w_r_active;
  logic [BEAT_LANES-1:0]      w_tmask_slice [NUM_BEATS];
  logic [BEAT_LANES*XLEN-1:0] w_data_slice  [NUM_BEATS];
  logic [PID_W-1:0]           w_in_first;
  logic [PID_W-1:0]           w_in_last;
  logic [PID_W-1:0]           w_next;
  logic                       w_last;
  logic                       w_valid;
  logic                       w_out_fire;
  logic                       w_ready_in;
  logic                       w_in_fire;

  generate
    for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_slice
      assign w_in_active[gi]   = |i_if.in_tmask[gi*BEAT_LANES +: BEAT_LANES];
      assign w_r_active[gi]    = |r_tmask[gi*BEAT_LANES +: BEAT_LANES];
      assign w_tmask_slice[gi] = r_tmask[gi*BEAT_LANES +: BEAT_LANES];
      assign w_data_slice[gi]  = r_data[gi*BEAT_LANES*XLEN +: BEAT_LANES*XLEN];
    end
  endgenerate

  // An all-zero mask leaves first/last at slice 0, giving a single empty beat.
  always_comb begin
    w_in_first = '0;
    w_in_last  = '0;
    w_next     = r_pid;
    for (int k = NUM_BEATS - 1; k >= 0; k--) begin
      if (w_in_active[k]) w_in_first = PID_W'(k);
      if (w_r_active[k] && (k > int'(r_pid))) w_next = PID_W'(k);
    end
    for (int k = 0; k < NUM_BEATS; k++) begin
      if (w_in_active[k]) w_in_last = PID_W'(k);
    end
  end

  assign w_last     = (r_pid == r_last_pid);
  assign w_valid    = !reset && (r_state == SEND);
  assign w_out_fire = w_valid && i_if.ready_out;
  assign w_ready_in = !reset && ((r_state == IDLE) || (w_out_fire && w_last));
  assign w_in_fire  = i_if.valid_in && w_ready_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pid   <= '0;
      r_first <= 1'b0;
    end else if (w_in_fire) begin
      r_state <= SEND;
      r_pid   <= w_in_first;
      r_first <= 1'b1;
    end else if (w_out_fire) begin
      if (w_last) begin
        r_state <= IDLE;
      end else begin
        r_pid   <= w_next;
        r_first <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_uuid     <= i_if.in_uuid;
      r_wid      <= i_if.in_wid;
      r_PC       <= i_if.in_PC;
      r_wb       <= i_if.in_wb;
      r_rd       <= i_if.in_rd;
      r_tmask    <= i_if.in_tmask;
      r_data     <= i_if.in_data;
      r_sop      <= i_if.in_sop;
      r_eop      <= i_if.in_eop;
      r_last_pid <= w_in_last;
    end
  end

  assign i_if.ready_in  = w_ready_in;
  assign i_if.valid_out = w_valid;
  assign i_if.out_uuid  = r_uuid;
  assign i_if.out_wid   = r_wid;
  assign i_if.out_PC    = r_PC;
  assign i_if.out_wb    = r_wb;
  assign i_if.out_rd    = r_rd;
  assign i_if.out_tmask = w_tmask_slice[r_pid];
  assign i_if.out_data  = w_data_slice[r_pid];
  assign i_if.out_sop   = r_sop && r_first;
  assign i_if.out_eop   = r_eop && w_last;
  assign i_if.out_pid   = r_pid;
endmodule

// File: tb/tb_vx_commit_packetizer.sv
// Directed and short randomized stimulus; expected beats are built from each offered
// result and queued, then compared against every beat the packetizer emits.
module tb_vx_commit_packetizer;
  localparam int NL = 8;
  localparam int BL = 4;
  localparam int XL = 32;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  typedef struct {
    logic [43:0]    uuid;
    logic           wb;
    logic [4:0]     rd;
    logic           pid;
    logic [3:0]     tmask;
    logic [127:0]   data;
    logic           sop;
    logic           eop;
  } beat_t;

  beat_t sb[$];

  vx_commit_packetizer_if #(.NUM_LANES(NL), .BEAT_LANES(BL), .XLEN(XL)) bus ();

  vx_commit_packetizer #(.NUM_LANES(NL), .BEAT_LANES(BL), .XLEN(XL)) dut (
    .clk   (clk),
    .reset (reset),
    .i_if  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Reference slicing: every active slice in ascending order, or slice 0 alone if none.
  task automatic push_expected(input logic [43:0] uuid, input logic wb, input logic [4:0] rd,
                               input logic [7:0] tm, input logic [255:0] data,
                               input logic sop, input logic eop);
    int first = -1;
    int last  = -1;
    beat_t e;
    for (int k = 0; k < 2; k++) begin
      if (tm[k*4 +: 4] != 4'h0) begin
        if (first < 0) first = k;
        last = k;
      end
    end
    if (first < 0) begin
      first = 0;
      last  = 0;
    end
    for (int k = first; k <= last; k++) begin
      if (k == first || tm[k*4 +: 4] != 4'h0) begin
        e.uuid  = uuid;
        e.wb    = wb;
        e.rd    = rd;
        e.pid   = 1'(k);
        e.tmask = tm[k*4 +: 4];
        e.data  = data[k*128 +: 128];
        e.sop   = sop && (k == first);
        e.eop   = eop && (k == last);
        sb.push_back(e);
      end
    end
  endtask

  // One clock: sample at negedge, score any visible beat, then step past the edge.
  task automatic tick(output logic s_in_fire, output logic s_ready_in, output logic s_valid);
    @(negedge clk);
    s_ready_in = bus.ready_in;
    s_valid    = bus.valid_out;
    s_in_fire  = bus.valid_in && bus.ready_in;
    if (bus.valid_out) begin
      check("beat_expected", 256'(sb.size() != 0), 256'(1));
      if (sb.size() != 0) begin
        check("pid",   256'(bus.out_pid),   256'(sb[0].pid));
        check("tmask", 256'(bus.out_tmask), 256'(sb[0].tmask));
        check("data",  256'(bus.out_data),  256'(sb[0].data));
        check("sop",   256'(bus.out_sop),   256'(sb[0].sop));
        check("eop",   256'(bus.out_eop),   256'(sb[0].eop));
        check("uuid",  256'(bus.out_uuid),  256'(sb[0].uuid));
        check("wb",    256'(bus.out_wb),    256'(sb[0].wb));
        check("rd",    256'(bus.out_rd),    256'(sb[0].rd));
        if (bus.ready_out) void'(sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [43:0] uuid, input logic wb, input logic [7:0] tm,
                      input logic [255:0] data, input logic sop, input logic eop,
                      input logic rnd, output int waited);
    logic f, r, v;
    bus.valid_in = 1'b1;
    bus.in_uuid  = uuid;
    bus.in_wid   = 2'(uuid);
    bus.in_PC    = 30'(uuid) ^ 30'h155;
    bus.in_wb    = wb;
    bus.in_rd    = 5'(uuid);
    bus.in_tmask = tm;
    bus.in_data  = data;
    bus.in_sop   = sop;
    bus.in_eop   = eop;
    push_expected(uuid, wb, 5'(uuid), tm, data, sop, eop);
    waited = 0;
    f = 1'b0;
    while (!f && waited < 20) begin
      if (rnd) bus.ready_out = 1'($urandom);
      tick(f, r, v);
      waited++;
    end
    check("accept_timeout", 256'(f), 256'(1));
  endtask

  task automatic rand_data(output logic [255:0] d);
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
  endtask

  initial begin
    logic f, r, v;
    logic [255:0] d;
    logic [7:0] tm;
    int w;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b1;
    bus.in_uuid = '0; bus.in_wid = '0; bus.in_PC = '0; bus.in_wb = 1'b0; bus.in_rd = '0;
    bus.in_tmask = '0; bus.in_data = '0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;

    tick(f, r, v);
    tick(f, r, v);
    check("reset_valid_out", 256'(v), 256'(0));
    check("reset_ready_in",  256'(r), 256'(0));
    reset = 1'b0;
    tick(f, r, v);
    check("post_reset_ready_in", 256'(r), 256'(1));
    $display("reset: valid_out=%0d ready_in=%0d", v, r);

    // Full mask: two beats, ready_in only alongside the last beat.
    rand_data(d);
    send(44'h1, 1'b1, 8'hFF, d, 1'b1, 1'b1, 1'b0, w);
    bus.valid_in = 1'b0;
    tick(f, r, v);
    check("full_b0_valid", 256'(v), 256'(1));
    check("full_b0_ready_in", 256'(r), 256'(0));
    tick(f, r, v);
    check("full_b1_valid", 256'(v), 256'(1));
    check("full_b1_ready_in", 256'(r), 256'(1));
    tick(f, r, v);
    check("full_idle_after", 256'(v), 256'(0));
    $display("txn full mask: done queue=%0d", sb.size());

    // Upper slice only.
    rand_data(d);
    d[4*32 +: 32] = 32'h1234;
    send(44'h2, 1'b1, 8'hF0, d, 1'b1, 1'b1, 1'b0, w);
    bus.valid_in = 1'b0;
    tick(f, r, v);
    check("upper_valid", 256'(v), 256'(1));
    check("upper_lane4", 256'(bus.out_data[31:0]), 256'(32'h1234));
    tick(f, r, v);
    check("upper_single", 256'(v), 256'(0));
    $display("txn upper slice: done queue=%0d", sb.size());

    // Empty mask.
    rand_data(d);
    send(44'h3, 1'b0, 8'h00, d, 1'b1, 1'b1, 1'b0, w);
    bus.valid_in = 1'b0;
    tick(f, r, v);
    check("empty_valid", 256'(v), 256'(1));
    tick(f, r, v);
    check("empty_single", 256'(v), 256'(0));
    $display("txn empty mask: done queue=%0d", sb.size());

    // Backpressure: beat 0 held for three stalled cycles.
    bus.ready_out = 1'b0;
    rand_data(d);
    send(44'h4, 1'b1, 8'hFF, d, 1'b1, 1'b0, 1'b0, w);
    bus.valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(f, r, v);
      check("stall_valid", 256'(v), 256'(1));
      check("stall_ready_in", 256'(r), 256'(0));
    end
    bus.ready_out = 1'b1;
    tick(f, r, v);
    tick(f, r, v);
    tick(f, r, v);
    check("stall_drained", 256'(v), 256'(0));
    $display("txn stall: done queue=%0d", sb.size());

    // Back-to-back results: four beats with no idle cycle.
    rand_data(d);
    send(44'h5, 1'b1, 8'hFF, d, 1'b0, 1'b0, 1'b0, w);
    rand_data(d);
    send(44'h6, 1'b1, 8'hFF, d, 1'b0, 1'b1, 1'b0, w);
    check("b2b_wait", 256'(w), 256'(2));
    bus.valid_in = 1'b0;
    tick(f, r, v);
    check("b2b_beat3_valid", 256'(v), 256'(1));
    tick(f, r, v);
    check("b2b_beat4_valid", 256'(v), 256'(1));
    tick(f, r, v);
    check("b2b_idle_after", 256'(v), 256'(0));
    $display("txn back-to-back: done queue=%0d", sb.size());

    // Reset after beat 0 discards beat 1.
    rand_data(d);
    send(44'h7, 1'b1, 8'hFF, d, 1'b1, 1'b1, 1'b0, w);
    bus.valid_in = 1'b0;
    tick(f, r, v);
    check("rst_mid_b0", 256'(v), 256'(1));
    reset = 1'b1;
    sb.delete();
    tick(f, r, v);
    check("rst_mid_valid", 256'(v), 256'(0));
    reset = 1'b0;
    tick(f, r, v);
    check("rst_mid_idle_valid", 256'(v), 256'(0));
    check("rst_mid_idle_ready", 256'(r), 256'(1));
    $display("txn reset mid-send: valid_out=%0d ready_in=%0d", v, r);

    // Randomized results under random backpressure.
    for (int n = 0; n < 8; n++) begin
      rand_data(d);
      tm = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      send(44'(100 + n), 1'($urandom), tm, d, 1'($urandom), 1'($urandom), 1'b1, w);
      bus.valid_in = 1'b0;
      $display("txn random %0d: tmask=%02h queue=%0d", n, tm, sb.size());
    end
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      bus.ready_out = 1'($urandom);
      tick(f, r, v);
    end
    bus.ready_out = 1'b1;
    check("drain_empty", 256'(sb.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
